cpu_halt_ctrl: RTL
==================

CPU_HALT_CTRL -- requirements
Module: cpu_halt_ctrl

Interface
REQ-001 SHALL have parameter HS_TIMEOUT, default 255, handshake-timeout limit in clk cycles; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port cptra_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port sleep_req  input  1  firmware pulse requesting CPU halt with clock gating.
REQ-005 SHALL have port generic_input_wires  input  64  SoC wires; any bit change is a wake event.
REQ-006 SHALL have port wake_irq  input  1  pending-interrupt wake event, level.
REQ-007 SHALL have port cptra_error_fatal  input  1  fatal error, level wake event.
REQ-008 SHALL have port cptra_in_debug_scan_mode  input  1  debug/scan, level wake event.
REQ-009 SHALL have port halt_req  output  1  halt request to core, level.
REQ-010 SHALL have port halt_ack  input  1  core halted acknowledge.
REQ-011 SHALL have port run_req  output  1  run request to core, level.
REQ-012 SHALL have port run_ack  input  1  core running acknowledge.
REQ-013 SHALL have port cpu_halt_status  output  1  to clock-gate logic; 1 = core halted, clock may be gated.
REQ-014 SHALL have port hs_timeout  output  1  one-cycle pulse on handshake timeout.

Function
REQ-015 SHALL flop generic_input_wires each cycle into gw_f; wire_change = (generic_input_wires != gw_f).
REQ-016 SHALL define wake = wire_change | wake_irq | cptra_error_fatal | cptra_in_debug_scan_mode | wake_pend.
REQ-017 SHALL set sticky wake_pend on wire_change in HALT_REQ or HALTED; clear it on entry to RUN_REQ or RUN.
REQ-018 SHALL implement registered FSM states RUN, HALT_REQ, HALTED, RUN_REQ.
REQ-019 RUN: all outputs 0; sleep_req & !wake -> HALT_REQ next cycle; sleep_req & wake -> stay RUN, request dropped.
REQ-020 HALT_REQ: halt_req=1; halt_ack -> HALTED next cycle, even if wake is active.
REQ-021 HALTED: cpu_halt_status=1, halt_req=0; wake -> RUN_REQ next cycle; sleep_req ignored.
REQ-022 RUN_REQ: run_req=1, cpu_halt_status=0; run_ack -> RUN next cycle; sleep_req ignored.
REQ-023 cpu_halt_status SHALL equal (state==HALTED), decoded from the state register, glitch-free.
REQ-024 halt_req, run_req, cpu_halt_status SHALL never be 1 in the same cycle.
REQ-025 sleep_req in HALT_REQ, HALTED or RUN_REQ SHALL be ignored and not queued.
REQ-026 halt_ack outside HALT_REQ and run_ack outside RUN_REQ SHALL be ignored.

Reset
REQ-027 On cptra_rst=1 at clk edge: state=RUN, gw_f=0, wake_pend=0, counter=0, all outputs 0.
REQ-028 Reset mid-handshake SHALL drop halt_req/run_req the next cycle with no timeout pulse.

Configuration
REQ-029 Macro CPU_HALT_CTRL_HS_TIMEOUT_EN enables the handshake timeout.
REQ-030 With macro: a 16-bit counter clears on entry to HALT_REQ/RUN_REQ and increments each cycle there.
REQ-031 With macro, HALT_REQ: counter==HS_TIMEOUT & !halt_ack -> RUN with halt_req dropped and a 1-cycle hs_timeout pulse.
REQ-032 With macro, RUN_REQ: counter==HS_TIMEOUT pulses hs_timeout once, holds run_req, stays in RUN_REQ; the counter saturates.
REQ-033 Ack in the same cycle as counter==HS_TIMEOUT SHALL win: normal transition, no pulse.
REQ-034 Without macro: no counter, hs_timeout tied 0, FSM waits indefinitely for acks.

Verification
REQ-035 Reset, sleep_req pulse; halt_ack after 3 cycles -> halt_req high 3 cycles, then cpu_halt_status=1 one cycle after ack.
REQ-036 In HALTED, flip generic_input_wires[17] -> next cycle RUN_REQ, status=0, run_req=1; run_ack -> RUN.
REQ-037 sleep_req with cptra_error_fatal=1 in same cycle -> stays RUN, halt_req never asserts.
REQ-038 Flip wire[0] during HALT_REQ, then halt_ack -> HALTED exactly 1 cycle, then RUN_REQ via wake_pend.
REQ-039 Macro on, HS_TIMEOUT=8, no halt_ack -> hs_timeout pulses once, 8 cycles after entering HALT_REQ, then RUN; macro off -> waits, hs_timeout=0.
REQ-040 Assert cptra_rst while in RUN_REQ -> next cycle run_req=0, state RUN, hs_timeout=0.

Source files
------------

// File: rtl/cpu_halt_ctrl.sv
// CPU halt/run handshake controller: the RUN/HALT_REQ/HALTED/RUN_REQ FSM gates the core clock; outputs are registered.
// Optional handshake timeout under `CPU_HALT_CTRL_HS_TIMEOUT_EN; its hs_timeout pulse is registered with the resulting state update.
module cpu_halt_ctrl #(
    parameter int unsigned HS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        cptra_rst,
    input  logic        sleep_req,
    input  logic [63:0] generic_input_wires,
    input  logic        wake_irq,
    input  logic        cptra_error_fatal,
    input  logic        cptra_in_debug_scan_mode,
    output logic        halt_req,
    input  logic        halt_ack,
    output logic        run_req,
    input  logic        run_ack,
    output logic        cpu_halt_status,
    output logic        hs_timeout
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_HALT_REQ = 2'd1,
        S_HALTED   = 2'd2,
        S_RUN_REQ  = 2'd3
    } state_t;

    if (HS_TIMEOUT < 1 || HS_TIMEOUT > 65535) begin : g_bad_hs_timeout
        $error("cpu_halt_ctrl: HS_TIMEOUT must be in 1..65535");
    end

    state_t      r_state;
    logic [63:0] r_gw_f;
    logic        r_wake_pend;
    logic        r_halt_req;
    logic        r_run_req;
    logic        r_halted;

    state_t      w_nxt;
    logic        w_wire_change;
    logic        w_wake;
    logic        w_cnt_hit;
    logic        w_to_fire;

    assign w_wire_change = (generic_input_wires != r_gw_f);
    assign w_wake        = w_wire_change | wake_irq | cptra_error_fatal
                         | cptra_in_debug_scan_mode | r_wake_pend;

    // A same-cycle ack always beats the timeout.
    assign w_to_fire = w_cnt_hit &&
                       (((r_state == S_HALT_REQ) && !halt_ack) ||
                        ((r_state == S_RUN_REQ)  && !run_ack));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_RUN:      if (sleep_req && !w_wake) w_nxt = S_HALT_REQ;
            S_HALT_REQ: begin
                if (halt_ack)       w_nxt = S_HALTED;
                else if (w_to_fire) w_nxt = S_RUN;
            end
            S_HALTED:   if (w_wake) w_nxt = S_RUN_REQ;
            S_RUN_REQ:  if (run_ack) w_nxt = S_RUN;
            default:    w_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cptra_rst) begin
            r_state     <= S_RUN;
            r_gw_f      <= '0;
            r_wake_pend <= 1'b0;
            r_halt_req  <= 1'b0;
            r_run_req   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_gw_f  <= generic_input_wires;
            // Remembers wire activity seen while the core was being parked.
            if ((w_nxt == S_RUN) || (w_nxt == S_RUN_REQ))
                r_wake_pend <= 1'b0;
            else if (w_wire_change && ((r_state == S_HALT_REQ) || (r_state == S_HALTED)))
                r_wake_pend <= 1'b1;
            r_halt_req <= (w_nxt == S_HALT_REQ);
            r_run_req  <= (w_nxt == S_RUN_REQ);
            r_halted   <= (w_nxt == S_HALTED);
        end
    end

    assign halt_req        = r_halt_req;
    assign run_req         = r_run_req;
    assign cpu_halt_status = r_halted;

`ifdef CPU_HALT_CTRL_HS_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_to_fired;
    logic        r_hs_timeout;
    logic        w_entry;

    assign w_entry   = (w_nxt != r_state) && ((w_nxt == S_HALT_REQ) || (w_nxt == S_RUN_REQ));
    assign w_cnt_hit = (r_cnt == 16'(HS_TIMEOUT)) && !r_to_fired;

    always_ff @(posedge clk) begin
        if (cptra_rst) begin
            r_cnt        <= '0;
            r_to_fired   <= 1'b0;
            r_hs_timeout <= 1'b0;
        end else begin
            r_hs_timeout <= w_to_fire;
            if (w_entry) begin
                r_cnt      <= '0;
                r_to_fired <= 1'b0;
            end else if (r_halt_req || r_run_req) begin
                if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
                if (w_to_fire)         r_to_fired <= 1'b1;
            end
        end
    end

    assign hs_timeout = r_hs_timeout;
`else
    assign w_cnt_hit  = 1'b0;
    assign hs_timeout = 1'b0;
`endif

endmodule
